if_prefetch_fetch: RTL and testbench

- Next-generation instruction-fetch stage for the MIPS pipeline.
- Holds the PC, the loadable instruction memory and the next-PC select, as the current fetch stage does.
- Adds a parametrised prefetch queue, so fetch is decoupled from ID through a valid/ready handshake.
- Adds redirect flush, program-halt detection and out-of-range fetch protection.
- Sits between the debug/UART program loader plus branch/jump resolution logic and the IF/ID boundary.

---
 rtl/if_pkg.sv | 58 +++++
 rtl/if_fetch_queue.sv | 69 ++++++
 rtl/if_prefetch_fetch.sv | 174 +++++++++++++++++
 tb/tb_if_prefetch_fetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and helpers for the prefetching instruction-fetch
//               stage: queue entry layout, next-PC select and PC priority mux.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int unsigned c_word_bits = 32;
    localparam logic [c_word_bits-1:0] c_halt_instr_default = 32'hFFFF_FFFF;

    // One prefetched instruction together with the PC it was fetched from
    typedef struct packed {
        logic [c_word_bits-1:0] pc;
        logic [c_word_bits-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JALR   = 2'd3
    } next_pc_sel_t;

    // JALR outranks jump, jump outranks branch
    function automatic next_pc_sel_t select_next_pc(
        input logic is_jalr,
        input logic is_jump,
        input logic pc_source
    );
        next_pc_sel_t sel;
        if (is_jalr)        sel = SEL_JALR;
        else if (is_jump)   sel = SEL_JUMP;
        else if (pc_source) sel = SEL_BRANCH;
        else                sel = SEL_SEQ;
        return sel;
    endfunction

    function automatic logic [c_word_bits-1:0] next_pc(
        input next_pc_sel_t           sel,
        input logic [c_word_bits-1:0] pc,
        input logic [c_word_bits-1:0] rs,
        input logic [c_word_bits-1:0] jump_target,
        input logic [c_word_bits-1:0] branch_target
    );
        logic [c_word_bits-1:0] result;
        case (sel)
            SEL_JALR:   result = rs;
            SEL_JUMP:   result = jump_target;
            SEL_BRANCH: result = branch_target;
            default:    result = pc + c_word_bits'(4);
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Power-of-two FIFO of fetch entries with push, pop, flush and
//               occupancy count. Decouples instruction fetch from decode.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_entry,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned        c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w + 1)'(DEPTH);

    fetch_entry_t       r_slots [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    // Pop only real entries; a push into a full queue is allowed only alongside a pop
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_full) || w_do_pop);

    // Payload storage carries no reset; o_valid masks stale slots
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_slots[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything queued
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_slots[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_prefetch_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_fetch
// Description : Prefetching MIPS instruction-fetch stage. Owns the PC, the
//               loadable instruction memory and next-PC select, and feeds ID
//               through a valid/ready prefetch queue with redirect flush, halt
//               detection and out-of-range fetch protection.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_fetch
    import if_pkg::*;
#(
    parameter int unsigned          BITS_SIZE   = c_word_bits,
    parameter int unsigned          SIZE_TOTAL  = 256,
    parameter int unsigned          QUEUE_DEPTH = 4,
    parameter logic [BITS_SIZE-1:0] HALT_INSTR  = c_halt_instr_default
)(
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_step,
    input  logic                         i_flag_write_intruc,
    input  logic [BITS_SIZE-1:0]         i_instruction_address,
    input  logic [BITS_SIZE-1:0]         i_instruction,
    input  logic                         i_is_JALR,
    input  logic                         i_is_jump,
    input  logic                         i_pc_source,
    input  logic [BITS_SIZE-1:0]         i_rs,
    input  logic [BITS_SIZE-1:0]         i_suma_jump,
    input  logic [BITS_SIZE-1:0]         i_suma_branch,
    input  logic                         i_id_ready,
    output logic                         o_valid,
    output logic [BITS_SIZE-1:0]         o_instruction,
    output logic [BITS_SIZE-1:0]         o_IF_PC,
    output logic [BITS_SIZE-1:0]         o_IF_PC4,
    output logic [BITS_SIZE-1:0]         o_IF_PC8,
    output logic                         o_halted,
    output logic [$clog2(QUEUE_DEPTH):0] o_queue_count
);

    localparam int unsigned          c_words    = SIZE_TOTAL / 4;
    localparam int unsigned          c_addr_w   = $clog2(SIZE_TOTAL);
    localparam int unsigned          c_cnt_w    = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [BITS_SIZE-1:0] c_pc_limit = BITS_SIZE'(SIZE_TOTAL);
    localparam logic [c_cnt_w-1:0]   c_depth    = c_cnt_w'(QUEUE_DEPTH);

    logic [BITS_SIZE-1:0] r_mem [c_words];
    logic [BITS_SIZE-1:0] r_pc;
    logic [BITS_SIZE-1:0] r_rdata;
    logic [BITS_SIZE-1:0] r_inflight_pc;
    logic                 r_inflight;
    logic                 r_halted;
    fetch_entry_t         r_last;
    logic [BITS_SIZE-1:0] r_last_pc4;
    logic [BITS_SIZE-1:0] r_last_pc8;

    next_pc_sel_t         w_sel;
    logic [BITS_SIZE-1:0] w_next_pc;
    logic                 w_redirect;
    logic                 w_halt_hit;
    logic                 w_room;
    logic                 w_in_range;
    logic                 w_try_issue;
    logic                 w_issue;
    logic                 w_range_halt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head_valid;
    fetch_entry_t         w_head;
    fetch_entry_t         w_push_entry;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_unused;

    assign w_redirect   = i_step && (i_is_JALR || i_is_jump || i_pc_source);
    assign w_sel        = select_next_pc(i_is_JALR, i_is_jump, i_pc_source);
    assign w_next_pc    = next_pc(w_sel, r_pc, i_rs, i_suma_jump, i_suma_branch);
    // A halt word arriving now blocks the issue that would otherwise overlap it
    assign w_halt_hit   = r_inflight && (r_rdata == HALT_INSTR);
    // Reserve a slot for the read in flight so its push is never dropped
    assign w_room       = (w_count + c_cnt_w'(r_inflight)) < c_depth;
    assign w_in_range   = (r_pc < c_pc_limit);
    assign w_try_issue  = i_step && !w_redirect && !r_halted && !w_halt_hit && w_room;
    assign w_issue      = w_try_issue && w_in_range;
    assign w_range_halt = w_try_issue && !w_in_range;
    assign w_push       = i_step && !w_redirect && r_inflight;
    assign w_pop        = i_step && !w_redirect && w_head_valid && i_id_ready;
    assign w_push_entry = '{pc: r_inflight_pc, instr: r_rdata};
    assign w_unused     = ^{i_instruction_address[BITS_SIZE-1:c_addr_w],
                            i_instruction_address[1:0]};

    // Program-load port; runs regardless of stepping and is untouched by reset
    always_ff @(posedge i_clk) begin
        if (i_flag_write_intruc) begin
            r_mem[i_instruction_address[c_addr_w-1:2]] <= i_instruction;
        end
    end

    // Synchronous fetch read; sees pre-write contents on a same-cycle load
    always_ff @(posedge i_clk) begin
        if (w_issue) begin
            r_rdata <= r_mem[r_pc[c_addr_w-1:2]];
        end
    end

    // PC, in-flight tracking and halt latch; a redirect discards the pending read
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_halted      <= 1'b0;
        end else if (w_redirect) begin
            r_pc       <= w_next_pc;
            r_inflight <= 1'b0;
            r_halted   <= 1'b0;
        end else if (i_step) begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= w_next_pc;
                r_inflight_pc <= r_pc;
            end
            if (w_halt_hit || w_range_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    if_fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (w_redirect),
        .i_push      (w_push),
        .i_push_entry(w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_head_valid),
        .o_count     (w_count)
    );

    // Present the head entry, or hold the last presented payload while empty
    always_comb begin
        if (w_head_valid) begin
            o_instruction = w_head.instr;
            o_IF_PC       = w_head.pc;
            o_IF_PC4      = w_head.pc + BITS_SIZE'(4);
            o_IF_PC8      = w_head.pc + BITS_SIZE'(8);
        end else begin
            o_instruction = r_last.instr;
            o_IF_PC       = r_last.pc;
            o_IF_PC4      = r_last_pc4;
            o_IF_PC8      = r_last_pc8;
        end
    end

    // Remember what was last presented so the payload is stable when empty
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last     <= '0;
            r_last_pc4 <= '0;
            r_last_pc8 <= '0;
        end else begin
            r_last     <= '{pc: o_IF_PC, instr: o_instruction};
            r_last_pc4 <= o_IF_PC4;
            r_last_pc8 <= o_IF_PC8;
        end
    end

    assign o_valid       = w_head_valid;
    assign o_halted      = r_halted;
    assign o_queue_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch_fetch
// Description : Scoreboard bench for if_prefetch_fetch. Expected delivery
//               streams come from a memory image walked sequentially until a
//               halt word or the end of memory; a monitor checks each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_fetch;

    localparam int unsigned BITS_SIZE   = 32;
    localparam int unsigned SIZE_TOTAL  = 256;
    localparam int unsigned QUEUE_DEPTH = 4;
    localparam int unsigned WORDS       = SIZE_TOTAL / 4;
    localparam logic [31:0] HALT        = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_step = 1'b0;
    logic        i_flag_write_intruc = 1'b0;
    logic [31:0] i_instruction_address = '0;
    logic [31:0] i_instruction = '0;
    logic        i_is_JALR = 1'b0;
    logic        i_is_jump = 1'b0;
    logic        i_pc_source = 1'b0;
    logic [31:0] i_rs = '0;
    logic [31:0] i_suma_jump = '0;
    logic [31:0] i_suma_branch = '0;
    logic        i_id_ready = 1'b0;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_IF_PC;
    logic [31:0] o_IF_PC4;
    logic [31:0] o_IF_PC8;
    logic        o_halted;
    logic [2:0]  o_queue_count;

    always #5 i_clk = ~i_clk;

    if_prefetch_fetch #(
        .BITS_SIZE  (BITS_SIZE),
        .SIZE_TOTAL (SIZE_TOTAL),
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .HALT_INSTR (HALT)
    ) dut (
        .i_clk                (i_clk),
        .i_reset              (i_reset),
        .i_step               (i_step),
        .i_flag_write_intruc  (i_flag_write_intruc),
        .i_instruction_address(i_instruction_address),
        .i_instruction        (i_instruction),
        .i_is_JALR            (i_is_JALR),
        .i_is_jump            (i_is_jump),
        .i_pc_source          (i_pc_source),
        .i_rs                 (i_rs),
        .i_suma_jump          (i_suma_jump),
        .i_suma_branch        (i_suma_branch),
        .i_id_ready           (i_id_ready),
        .o_valid              (o_valid),
        .o_instruction        (o_instruction),
        .o_IF_PC              (o_IF_PC),
        .o_IF_PC4             (o_IF_PC4),
        .o_IF_PC8             (o_IF_PC8),
        .o_halted             (o_halted),
        .o_queue_count        (o_queue_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [WORDS];
    logic [31:0] last_pc = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        model_mem[addr[7:2]]  = data;
        i_flag_write_intruc   = 1'b1;
        i_instruction_address = addr;
        i_instruction         = data;
        cycle();
        i_flag_write_intruc   = 1'b0;
    endtask

    // Everything the stage will deliver when fetching sequentially from start
    task automatic gen_stream(input logic [31:0] start);
        exp_q.delete();
        for (int unsigned a = start; a < SIZE_TOTAL; a += 4) begin
            exp_q.push_back('{pc: a, instr: model_mem[a / 4]});
            if (model_mem[a / 4] == HALT) break;
        end
    endtask

    task automatic do_reset();
        i_step  = 1'b0;
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  32'(o_valid), 32'd0);
        check({tag, "_instr"},  o_instruction, 32'd0);
        check({tag, "_pc"},     o_IF_PC, 32'd0);
        check({tag, "_pc4"},    o_IF_PC4, 32'd0);
        check({tag, "_pc8"},    o_IF_PC8, 32'd0);
        check({tag, "_halted"}, 32'(o_halted), 32'd0);
        check({tag, "_count"},  32'(o_queue_count), 32'd0);
    endtask

    task automatic redirect(input logic jalr, input logic jump, input logic br,
                            input logic [31:0] rs, input logic [31:0] jt, input logic [31:0] bt);
        logic [31:0] target;
        i_is_JALR     = jalr;
        i_is_jump     = jump;
        i_pc_source   = br;
        i_rs          = rs;
        i_suma_jump   = jt;
        i_suma_branch = bt;
        i_step        = 1'b1;
        cycle();
        i_is_JALR   = 1'b0;
        i_is_jump   = 1'b0;
        i_pc_source = 1'b0;
        target = jalr ? rs : (jump ? jt : bt);
        gen_stream(target);
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_count", 32'(o_queue_count), 32'd0);
        check("redirect_halt_clear", 32'(o_halted), 32'd0);
    endtask

    // Let the current stream finish; fetch must then stop with halt raised
    task automatic drain(input string tag);
        int n = 0;
        i_step     = 1'b1;
        i_id_ready = 1'b1;
        while (exp_q.size() != 0 && n < 400) begin
            cycle();
            n++;
        end
        repeat (4) cycle();
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid"},   32'(o_valid), 32'd0);
        check({tag, "_halted"},  32'(o_halted), 32'd1);
    endtask

    function automatic logic [31:0] head_pc();
        return (exp_q.size() != 0) ? exp_q[0].pc : 32'hFFFF_FFFF;
    endfunction

    // Scoreboard monitor: every accepted head entry must be the next expected one
    always @(negedge i_clk) begin
        if (!i_reset) begin
            check("occupancy_bound", 32'(o_queue_count <= QUEUE_DEPTH), 32'd1);
            if (i_step && !(i_is_JALR || i_is_jump || i_pc_source) && o_valid && i_id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery actual_pc=0x%08h required=none", o_IF_PC);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("deliver_pc",    o_IF_PC, e.pc);
                    check("deliver_instr", o_instruction, e.instr);
                    check("deliver_pc4",   o_IF_PC4, e.pc + 32'd4);
                    check("deliver_pc8",   o_IF_PC8, e.pc + 32'd8);
                end
                last_pc = o_IF_PC;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic jl, jp, br;
        cycle();
        do_reset();
        check_all_zero("reset");

        // Program image: eight marked words, then filler with no halt word
        for (int i = 0; i < WORDS; i++) begin
            load_word(32'(i * 4), (i < 8) ? 32'h2001_0001 + 32'(i) : 32'h2002_0000 + 32'(i));
        end
        gen_stream(32'd0);

        // Streaming start-up latency and throughput
        i_id_ready = 1'b1;
        i_step     = 1'b1;
        cycle();
        check("start_valid_c1", 32'(o_valid), 32'd0);
        cycle();
        check("start_valid_c2", 32'(o_valid), 32'd1);
        check("start_pc", o_IF_PC, 32'd0);
        repeat (6) cycle();

        // Back-pressure fills the queue and freezes the head
        i_id_ready = 1'b0;
        repeat (10) cycle();
        check("full_count", 32'(o_queue_count), 32'(QUEUE_DEPTH));
        check("full_head_pc", o_IF_PC, head_pc());
        i_id_ready = 1'b1;
        repeat (6) cycle();

        // Jump beats branch while full; new stream two cycles after redirect
        i_id_ready = 1'b0;
        repeat (6) cycle();
        redirect(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'h80);
        i_id_ready = 1'b1;
        cycle();
        check("redir_valid_c1", 32'(o_valid), 32'd0);
        cycle();
        check("redir_valid_c2", 32'(o_valid), 32'd1);
        check("redir_jump_pc", o_IF_PC, 32'h40);

        // JALR beats jump
        i_id_ready = 1'b0;
        repeat (6) cycle();
        redirect(1'b1, 1'b1, 1'b0, 32'h80, 32'h40, 32'h0);
        i_id_ready = 1'b1;
        cycle();
        cycle();
        check("jalr_valid", 32'(o_valid), 32'd1);
        check("jalr_pc", o_IF_PC, 32'h80);

        // Branch alone
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h20);
        cycle();
        cycle();
        check("branch_pc", o_IF_PC, 32'h20);

        // Halt word at 12: deliver 0..12 then stop
        i_step = 1'b0;
        load_word(32'd12, HALT);
        redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        drain("halt");
        check("halt_last_pc", last_pc, 32'd12);
        redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        drain("halt_again");

        // No halt word: run off the end of memory
        i_step = 1'b0;
        load_word(32'd12, 32'h2001_0004);
        redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        drain("range");
        check("range_last_pc", last_pc, 32'hFC);

        // Reset while half full and stalled; memory must survive
        i_id_ready = 1'b0;
        redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        n = 0;
        while (o_queue_count != 3'd2 && n < 20) begin
            cycle();
            n++;
        end
        check("half_full_reached", 32'(o_queue_count), 32'd2);
        i_step  = 1'b0;
        i_reset = 1'b1;
        cycle();
        check_all_zero("reset_mid");
        i_reset = 1'b0;
        exp_q.delete();
        gen_stream(32'd0);
        drain("after_reset");

        // Randomised traffic over a random image with sparse halt words
        do_reset();
        for (int i = 0; i < WORDS; i++) begin
            load_word(32'(i * 4), ($urandom_range(0, 99) < 6) ? HALT : $urandom);
        end
        gen_stream(32'd0);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                jl = 1'($urandom_range(0, 1));
                jp = 1'($urandom_range(0, 1));
                br = 1'($urandom_range(0, 1));
                if (!(jl || jp || br)) jp = 1'b1;
                redirect(jl, jp, br,
                         32'($urandom_range(0, 64) * 4),
                         32'($urandom_range(0, 64) * 4),
                         32'($urandom_range(0, 64) * 4));
            end else begin
                i_step     = ($urandom_range(0, 99) < 85);
                i_id_ready = ($urandom_range(0, 99) < 70);
                cycle();
            end
        end
        drain("random_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
